// File: rtl/winograd_input_transform_if.sv
// Tile-in / transformed-channel-out bus of the Winograd F(2x2,3x3) input transform.
//   i_tile, i_tile_valid, o_tile_ready : upstream tile handshake (M channels of 4x4 u8 pixels)
//   o_u, o_ch, o_last, o_valid, i_ready: downstream per-channel handshake (16 signed OW-bit elements)
// slave  : the transform block side
// master : the driving/consuming environment side
interface winograd_input_transform_if #(
  parameter int M  = 3,
  parameter int OW = 11
);
  localparam int CHW = (M > 1) ? $clog2(M) : 1;

  logic [M*128-1:0] i_tile;
  logic             i_tile_valid;
  logic             o_tile_ready;
  logic [16*OW-1:0] o_u;
  logic [CHW-1:0]   o_ch;
  logic             o_last;
  logic             o_valid;
  logic             i_ready;

  modport slave (
    input  i_tile, i_tile_valid, i_ready,
    output o_tile_ready, o_u, o_ch, o_last, o_valid
  );

  modport master (
    output i_tile, i_tile_valid, i_ready,
    input  o_tile_ready, o_u, o_ch, o_last, o_valid
  );
endinterface

// File: rtl/winograd_input_transform.sv
// Winograd F(2x2,3x3) input transform U = B^T d B, one channel per beat.
// A whole M-channel 4x4 tile is captured in IDLE, then channels are issued
// one per advancing cycle through a two-stage pipeline:
//   stage 1 (_p1): row transform T = B^T d (per column)
//   stage 2 (_p2): column transform U = T B (per row), drives the output bus
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : winograd_input_transform_if.slave (tile in, transformed channel out)
module winograd_input_transform #(
  parameter int M  = 3,
  parameter int OW = 11
) (
  input logic                       i_clk,
  input logic                       i_rst,
  winograd_input_transform_if.slave bus
);

  localparam int             CHW     = (M > 1) ? $clog2(M) : 1;
  localparam int             TILE_W  = M * 128;
  localparam logic [CHW-1:0] LAST_CH = CHW'(M - 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Unsigned pixel d[r][c] of channel k, zero-extended to a signed OW-bit value.
  function automatic logic signed [OW-1:0] pixel(input logic [TILE_W-1:0] tile,
                                                 input int k, input int r, input int c);
    logic [7:0] px;
    px = tile[(3-r)*M*32 + (M-1-k)*32 + (3-c)*8 +: 8];
    return $signed({{(OW-8){1'b0}}, px});
  endfunction

  state_t              state_q;
  logic [CHW-1:0]      ch_q;
  logic [TILE_W-1:0]   tile_q;
  logic                adv;
  logic                accept;

  logic signed [OW-1:0] t_d  [4][4];
  logic signed [OW-1:0] t_p1 [4][4];
  logic                 vld_p1;
  logic [CHW-1:0]       ch_p1;
  logic                 last_p1;

  logic [16*OW-1:0]     u_d;
  logic [16*OW-1:0]     u_p2;
  logic                 vld_p2;
  logic [CHW-1:0]       ch_p2;
  logic                 last_p2;

  // The whole pipeline (issue, both stages, FSM) moves only when the output
  // slot is empty or being consumed. Tile capture in IDLE is independent of
  // this so the ready/valid handshake upstream is never broken.
  assign adv    = !vld_p2 || bus.i_ready;
  assign accept = (state_q == IDLE) && bus.i_tile_valid;

  // ---- stage 0 -> 1: row transform of the channel selected by ch_q ----
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      t_d[0][c] = pixel(tile_q, int'(ch_q), 0, c) - pixel(tile_q, int'(ch_q), 2, c);
      t_d[1][c] = pixel(tile_q, int'(ch_q), 1, c) + pixel(tile_q, int'(ch_q), 2, c);
      t_d[2][c] = pixel(tile_q, int'(ch_q), 2, c) - pixel(tile_q, int'(ch_q), 1, c);
      t_d[3][c] = pixel(tile_q, int'(ch_q), 1, c) - pixel(tile_q, int'(ch_q), 3, c);
    end
  end

  // ---- stage 1 -> 2: column transform, packed U[r][c] at (15-(4r+c))*OW ----
  always_comb begin
    u_d = '0;
    for (int r = 0; r < 4; r++) begin
      u_d[(15-4*r)*OW +: OW] = t_p1[r][0] - t_p1[r][2];
      u_d[(14-4*r)*OW +: OW] = t_p1[r][1] + t_p1[r][2];
      u_d[(13-4*r)*OW +: OW] = t_p1[r][2] - t_p1[r][1];
      u_d[(12-4*r)*OW +: OW] = t_p1[r][1] - t_p1[r][3];
    end
  end

  // Control, valids and the output register (the output is cleared by reset
  // so a reset bus shows all-zero).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      ch_p2   <= '0;
      last_p2 <= 1'b0;
      u_p2    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_tile_valid) begin
            state_q <= ISSUE;
            ch_q    <= '0;
          end
        end
        ISSUE: begin
          if (adv) begin
            if (ch_q == LAST_CH) begin
              state_q <= IDLE;
              ch_q    <= '0;
            end else begin
              ch_q <= ch_q + CHW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (adv) begin
        vld_p1  <= (state_q == ISSUE);
        vld_p2  <= vld_p1;
        ch_p2   <= ch_p1;
        last_p2 <= last_p1;
        u_p2    <= u_d;
      end
    end
  end

  // Datapath registers without reset; their qualifying valids are reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      tile_q <= bus.i_tile;
    end
    if (adv && (state_q == ISSUE)) begin
      t_p1    <= t_d;
      ch_p1   <= ch_q;
      last_p1 <= (ch_q == LAST_CH);
    end
  end

  assign bus.o_tile_ready = (state_q == IDLE);
  assign bus.o_u          = u_p2;
  assign bus.o_ch         = ch_p2;
  assign bus.o_last       = last_p2;
  assign bus.o_valid      = vld_p2;

endmodule

// File: tb/tb_winograd_input_transform.sv
module tb_winograd_input_transform;
  localparam int M      = 3;
  localparam int OW     = 11;
  localparam int CHW    = 2;
  localparam int TILE_W = M * 128;

  typedef struct packed {
    logic [16*OW-1:0] u;
    logic [CHW-1:0]   ch;
    logic             last;
  } beat_t;

  typedef struct {
    logic [TILE_W-1:0] tile;
    int                sch;   // channel of the hand-derived spot value, -1 = none
    int                sr;
    int                sc;
    int                sexp;
    logic              rnd_rdy;
  } vec_t;

  logic clk;
  logic rst;
  winograd_input_transform_if #(.M(M), .OW(OW)) bus ();

  winograd_input_transform #(.M(M), .OW(OW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    beats    = 0;
  beat_t sb [$];
  int    acc_cyc [$];
  int    beat_cyc [$];
  int    beat_ch [$];

  logic rand_ready = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_bit = 1'b1;
  assign bus.i_ready = rand_ready ? rnd_bit : ready_force;

  logic spot_arm = 1'b0;
  int   spot_ch, spot_r, spot_c, spot_exp;
  int   spot_hits = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct double sum U[i][j] = sum_k sum_l BT[i][k] d[k][l] BT[j][l].
  function automatic logic [16*OW-1:0] model_u(input logic [TILE_W-1:0] t, input int k);
    int bt [4][4];
    int d  [4][4];
    int acc;
    logic [16*OW-1:0] u;
    bt[0] = '{1, 0, -1, 0};
    bt[1] = '{0, 1, 1, 0};
    bt[2] = '{0, -1, 1, 0};
    bt[3] = '{0, 1, 0, -1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        d[r][c] = int'(t[(3-r)*M*32 + (M-1-k)*32 + (3-c)*8 +: 8]);
    u = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++)
            acc += bt[i][a] * d[a][b] * bt[j][b];
        u[(15-(4*i+j))*OW +: OW] = acc[OW-1:0];
      end
    return u;
  endfunction

  function automatic logic [TILE_W-1:0] set_px(input logic [TILE_W-1:0] t, input int k,
                                              input int r, input int c, input logic [7:0] v);
    logic [TILE_W-1:0] x;
    x = t;
    x[(3-r)*M*32 + (M-1-k)*32 + (3-c)*8 +: 8] = v;
    return x;
  endfunction

  // Scoreboard push on acceptance, compare every cycle the output is valid
  // (so a stalled beat must stay equal to the queue head), pop on consumption.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_tile_valid && bus.o_tile_ready) begin
        for (int k = 0; k < M; k++) begin
          beat_t b;
          b.u    = model_u(bus.i_tile, k);
          b.ch   = CHW'(k);
          b.last = (k == M - 1);
          sb.push_back(b);
        end
        acc_cyc.push_back(cyc);
      end
      if (bus.o_valid) begin
        if (sb.size() == 0) begin
          chk("extra_beat", {255'd0, bus.o_valid}, 256'd0);
        end else begin
          chk("beat_u", bus.o_u, sb[0].u);
          chk("beat_ch", bus.o_ch, sb[0].ch);
          chk("beat_last", bus.o_last, sb[0].last);
          if (bus.i_ready) begin
            if (spot_arm && int'(bus.o_ch) == spot_ch) begin
              logic signed [OW-1:0] e;
              e = bus.o_u[(15-(4*spot_r+spot_c))*OW +: OW];
              chk_i("spot_value", int'(e), spot_exp);
              spot_arm = 1'b0;
              spot_hits++;
            end
            void'(sb.pop_front());
            beats++;
            beat_cyc.push_back(cyc);
            beat_ch.push_back(int'(bus.o_ch));
          end
        end
      end
    end
  end

  task automatic send_tile(input logic [TILE_W-1:0] t);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.i_tile       = t;
    bus.i_tile_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_tile_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.i_tile_valid = 1'b0;
    chk_i("accept_timeout", (n < 100) ? 1 : 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_i("drain_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  vec_t vecs [6];

  initial begin
    logic [TILE_W-1:0] t;
    int b0, a0, n;

    // Stimulus table with hand-derived spot values.
    vecs[0] = '{{48{8'h01}}, 0, 1, 1, 4, 1'b0};        // all ones: U[1][1]=4
    t = '0; t = set_px(t, 1, 1, 1, 8'd255);
    vecs[1] = '{t, 1, 1, 2, -255, 1'b0};               // ch1 d11=255: U[1][2]=-255
    vecs[2] = '{{48{8'hFF}}, 2, 1, 1, 1020, 1'b1};     // all 255: U[1][1]=1020
    t = '0;
    for (int k = 0; k < M; k++) begin
      t = set_px(t, k, 0, 0, 8'd255);
      t = set_px(t, k, 2, 2, 8'd255);
    end
    vecs[3] = '{t, 0, 0, 0, 510, 1'b0};                // d00-d02-d20+d22 = 510
    t = '0; t = set_px(t, 0, 0, 0, 8'd255);
    vecs[4] = '{t, 0, 0, 0, 255, 1'b0};                // d00 alone: U[0][0]=255
    for (int w = 0; w < TILE_W / 32; w++) t[w*32 +: 32] = $urandom;
    vecs[5] = '{t, -1, 0, 0, 0, 1'b1};

    rst = 1'b1;
    bus.i_tile = '0;
    bus.i_tile_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_ch", bus.o_ch, 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_u", bus.o_u, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_tile_ready", bus.o_tile_ready, 1);

    // Latency and ordering with i_ready high.
    bus.i_tile = vecs[0].tile;
    bus.i_tile_valid = 1'b1;
    @(negedge clk);
    chk("lat_ready", bus.o_tile_ready, 1);
    @(posedge clk); #1;
    bus.i_tile_valid = 1'b0;
    chk("lat_T0_valid", bus.o_valid, 0);
    chk("lat_busy", bus.o_tile_ready, 0);
    @(posedge clk); #1;
    chk("lat_T1_valid", bus.o_valid, 0);
    for (int k = 0; k < M; k++) begin
      @(posedge clk); #1;
      chk("lat_seq_valid", bus.o_valid, 1);
      chk_i("lat_seq_ch", int'(bus.o_ch), k);
      chk_i("lat_seq_last", int'(bus.o_last), (k == M - 1) ? 1 : 0);
    end
    drain();

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      int h;
      h = spot_hits;
      if (vecs[i].sch >= 0) begin
        spot_ch  = vecs[i].sch;
        spot_r   = vecs[i].sr;
        spot_c   = vecs[i].sc;
        spot_exp = vecs[i].sexp;
        spot_arm = 1'b1;
      end
      rand_ready = vecs[i].rnd_rdy;
      b0 = beats;
      send_tile(vecs[i].tile);
      drain();
      rand_ready = 1'b0;
      chk_i("vec_beats", beats - b0, M);
      if (vecs[i].sch >= 0) chk_i("vec_spot_seen", spot_hits - h, 1);
    end

    // Backpressure after the first beat.
    b0 = beats;
    send_tile(vecs[1].tile);
    n = 0;
    while (!bus.o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_i("bp_first_timeout", (n < 50) ? 1 : 0, 1);
    ready_force = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.o_valid, 1);
      chk("bp_hold_ch", bus.o_ch, 0);
      chk("bp_tile_ready", bus.o_tile_ready, 0);
    end
    ready_force = 1'b1;
    drain();
    chk_i("bp_beats", beats - b0, M);

    // Back-to-back tiles with i_tile_valid held high.
    b0 = beats;
    a0 = acc_cyc.size();
    @(posedge clk); #1;
    bus.i_tile = vecs[5].tile;
    bus.i_tile_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < a0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.o_tile_ready) begin
        @(posedge clk); #1;
        bus.i_tile = vecs[2].tile;
      end
    end
    bus.i_tile_valid = 1'b0;
    chk_i("b2b_timeout", (n < 100) ? 1 : 0, 1);
    drain();
    chk_i("b2b_beats", beats - b0, 2 * M);
    if (acc_cyc.size() >= a0 + 2)
      chk_i("b2b_accept_gap", acc_cyc[a0+1] - acc_cyc[a0], M + 1);
    if (beats - b0 == 2 * M) begin
      chk_i("b2b_beat_gap", beat_cyc[b0+M] - beat_cyc[b0], M + 1);
      chk_i("b2b_wrap_hi", beat_ch[b0+M-1], M - 1);
      chk_i("b2b_wrap_lo", beat_ch[b0+M], 0);
    end

    // Reset while channel 1 is on the output.
    send_tile(vecs[4].tile);
    n = 0;
    while (!(bus.o_valid && bus.o_ch == CHW'(1)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_i("mid_rst_timeout", (n < 50) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_ready", bus.o_tile_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.o_valid, 0);
    end
    b0 = beats;
    send_tile(vecs[3].tile);
    drain();
    chk_i("post_rst_beats", beats - b0, M);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1);
  end
endmodule
